equeue_param: RTL and testbench

Parametrised collapsing issue queue for the integer/execution cluster, and the next generation of the fixed 4-entry integer queue. It sits between dispatch and one execution unit's issue stage. It buffers up to DEPTH renamed instructions and captures operand data from the CDB, including for the instruction being dispatched. Each cycle it issues the oldest instruction whose operands are both valid. New relative to the previous queue: arbitrary depth and widths, gap-free compaction, full flush, and occupancy outputs.

---
 rtl/equeue_pkg.sv | 20 ++
 rtl/equeue_wakeup.sv | 26 ++
 rtl/equeue_param.sv | 188 ++++++++++++++++++
 tb/tb_equeue_param.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/equeue_pkg.sv
// Shared defaults and the issue-queue entry record for equeue_param.
package equeue_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_OPC_W  = 6;
    localparam int DEF_TAG_W  = 6;
    localparam int DEF_DATA_W = 32;

    typedef struct packed {
        logic [DEF_OPC_W-1:0]  opcode;
        logic [DEF_TAG_W-1:0]  rdtag;
        logic [DEF_TAG_W-1:0]  rstag;
        logic [DEF_TAG_W-1:0]  rttag;
        logic [DEF_DATA_W-1:0] rsdata;
        logic [DEF_DATA_W-1:0] rtdata;
        logic                  rsvalid;
        logic                  rtvalid;
    } entry_t;

endpackage

// File: rtl/equeue_wakeup.sv
// One-operand CDB wakeup: tag compare plus data/valid capture.
module equeue_wakeup
    import equeue_pkg::*;
#(
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic [TAG_W-1:0]  op_tag,
    input  logic [DATA_W-1:0] op_data,
    input  logic              op_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    logic hit;

    always_comb begin
        hit       = cdb_valid & ~op_valid & (cdb_tag == op_tag);
        out_valid = op_valid | hit;
        out_data  = hit ? cdb_data : op_data;
    end

endmodule

// File: rtl/equeue_param.sv
// Parametrised collapsing issue queue: oldest-ready select, gap-free compaction, CDB wakeup.
module equeue_param
    import equeue_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int OPC_W  = DEF_OPC_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dispatch_en,
    input  logic [OPC_W-1:0]  dispatch_opcode,
    input  logic [TAG_W-1:0]  dispatch_rdtag,
    input  logic [TAG_W-1:0]  dispatch_rstag,
    input  logic [TAG_W-1:0]  dispatch_rttag,
    input  logic [DATA_W-1:0] dispatch_rsdata,
    input  logic [DATA_W-1:0] dispatch_rtdata,
    input  logic              dispatch_rsvalid,
    input  logic              dispatch_rtvalid,
    output logic              dispatch_ready,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              flush,
    output logic              issue_valid,
    output logic [OPC_W-1:0]  issue_opcode,
    output logic [TAG_W-1:0]  issue_rdtag,
    output logic [DATA_W-1:0] issue_rsdata,
    output logic [DATA_W-1:0] issue_rtdata,
    input  logic              issue_ack,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    localparam int IDX_W = $clog2(DEPTH);

    // Same field order as equeue_pkg::entry_t, sized by the instance parameters.
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [TAG_W-1:0]  rdtag;
        logic [TAG_W-1:0]  rstag;
        logic [TAG_W-1:0]  rttag;
        logic [DATA_W-1:0] rsdata;
        logic [DATA_W-1:0] rtdata;
        logic              rsvalid;
        logic              rtvalid;
    } ent_t;

    ent_t             entry_q [DEPTH];
    ent_t             entry_d [DEPTH];
    ent_t             woken   [DEPTH+1];
    ent_t             sel_ent;
    ent_t             src;
    logic [CNT_W-1:0] count_q, count_d, wr_idx;
    logic [DEPTH-1:0] ready;
    logic             any_ready, issue_fire, dispatch_fire;
    logic [IDX_W-1:0] sel_idx;

    logic [TAG_W-1:0]  rs_tag_in   [DEPTH+1];
    logic [TAG_W-1:0]  rt_tag_in   [DEPTH+1];
    logic [DATA_W-1:0] rs_data_in  [DEPTH+1];
    logic [DATA_W-1:0] rt_data_in  [DEPTH+1];
    logic [DATA_W-1:0] rs_data_out [DEPTH+1];
    logic [DATA_W-1:0] rt_data_out [DEPTH+1];
    logic [DEPTH:0]    rs_valid_in, rt_valid_in, rs_valid_out, rt_valid_out;

    // Index DEPTH is the dispatch port; the rest are the stored entries.
    for (genvar g = 0; g <= DEPTH; g++) begin : g_wake
        if (g < DEPTH) begin : g_ent
            assign rs_tag_in[g]   = entry_q[g].rstag;
            assign rt_tag_in[g]   = entry_q[g].rttag;
            assign rs_data_in[g]  = entry_q[g].rsdata;
            assign rt_data_in[g]  = entry_q[g].rtdata;
            assign rs_valid_in[g] = entry_q[g].rsvalid;
            assign rt_valid_in[g] = entry_q[g].rtvalid;
        end else begin : g_disp
            assign rs_tag_in[g]   = dispatch_rstag;
            assign rt_tag_in[g]   = dispatch_rttag;
            assign rs_data_in[g]  = dispatch_rsdata;
            assign rt_data_in[g]  = dispatch_rtdata;
            assign rs_valid_in[g] = dispatch_rsvalid;
            assign rt_valid_in[g] = dispatch_rtvalid;
        end

        equeue_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_rs (
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .op_tag    (rs_tag_in[g]),
            .op_data   (rs_data_in[g]),
            .op_valid  (rs_valid_in[g]),
            .out_data  (rs_data_out[g]),
            .out_valid (rs_valid_out[g])
        );

        equeue_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_rt (
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .op_tag    (rt_tag_in[g]),
            .op_data   (rt_data_in[g]),
            .op_valid  (rt_valid_in[g]),
            .out_data  (rt_data_out[g]),
            .out_valid (rt_valid_out[g])
        );
    end

    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ready[i] = (CNT_W'(i) < count_q) && entry_q[i].rsvalid && entry_q[i].rtvalid;
            if (ready[i] && !any_ready) begin
                any_ready = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        sel_ent = entry_q[sel_idx];
    end

    always_comb begin
        issue_valid    = any_ready & ~flush;
        issue_fire     = issue_valid & issue_ack;
        full           = (count_q == CNT_W'(DEPTH));
        empty          = (count_q == '0);
        dispatch_ready = ~flush & (~full | issue_fire);
        dispatch_fire  = dispatch_en & dispatch_ready;
        count          = count_q;
        issue_opcode   = issue_valid ? sel_ent.opcode : '0;
        issue_rdtag    = issue_valid ? sel_ent.rdtag  : '0;
        issue_rsdata   = issue_valid ? sel_ent.rsdata : '0;
        issue_rtdata   = issue_valid ? sel_ent.rtdata : '0;
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            woken[i]         = entry_q[i];
            woken[i].rsdata  = rs_data_out[i];
            woken[i].rsvalid = rs_valid_out[i];
            woken[i].rtdata  = rt_data_out[i];
            woken[i].rtvalid = rt_valid_out[i];
        end
        woken[DEPTH].opcode  = dispatch_opcode;
        woken[DEPTH].rdtag   = dispatch_rdtag;
        woken[DEPTH].rstag   = dispatch_rstag;
        woken[DEPTH].rttag   = dispatch_rttag;
        woken[DEPTH].rsdata  = rs_data_out[DEPTH];
        woken[DEPTH].rtdata  = rt_data_out[DEPTH];
        woken[DEPTH].rsvalid = rs_valid_out[DEPTH];
        woken[DEPTH].rtvalid = rt_valid_out[DEPTH];
    end

    // Slots at/above the issued one shift down; slots past the new count are zeroed so
    // stale contents (including spurious wakeups of vacant slots) never linger.
    always_comb begin
        count_d = flush ? '0 : count_q + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
        wr_idx  = count_q - CNT_W'(issue_fire);
        src     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            src = woken[i];
            if (issue_fire && (IDX_W'(i) >= sel_idx)) begin
                src = woken[i+1];
            end
            if (dispatch_fire && (CNT_W'(i) == wr_idx)) begin
                src = woken[DEPTH];
            end
            entry_d[i] = (!flush && (CNT_W'(i) < count_d)) ? src : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule

// File: tb/tb_equeue_param.sv
// Directed plus randomized bench for equeue_param against an in-order queue model.
module tb_equeue_param;

    localparam int DEPTH  = 4;
    localparam int OPC_W  = 6;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              dispatch_en;
    logic [OPC_W-1:0]  dispatch_opcode;
    logic [TAG_W-1:0]  dispatch_rdtag, dispatch_rstag, dispatch_rttag;
    logic [DATA_W-1:0] dispatch_rsdata, dispatch_rtdata;
    logic              dispatch_rsvalid, dispatch_rtvalid;
    logic              dispatch_ready;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              flush;
    logic              issue_valid;
    logic [OPC_W-1:0]  issue_opcode;
    logic [TAG_W-1:0]  issue_rdtag;
    logic [DATA_W-1:0] issue_rsdata, issue_rtdata;
    logic              issue_ack;
    logic [CNT_W-1:0]  count;
    logic              empty, full;

    equeue_param #(
        .DEPTH(DEPTH), .OPC_W(OPC_W), .TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .dispatch_en(dispatch_en), .dispatch_opcode(dispatch_opcode),
        .dispatch_rdtag(dispatch_rdtag), .dispatch_rstag(dispatch_rstag),
        .dispatch_rttag(dispatch_rttag), .dispatch_rsdata(dispatch_rsdata),
        .dispatch_rtdata(dispatch_rtdata), .dispatch_rsvalid(dispatch_rsvalid),
        .dispatch_rtvalid(dispatch_rtvalid), .dispatch_ready(dispatch_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_rdtag(issue_rdtag), .issue_rsdata(issue_rsdata),
        .issue_rtdata(issue_rtdata), .issue_ack(issue_ack),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OPC_W-1:0]  op;
        logic [TAG_W-1:0]  rd, rs, rt;
        logic [DATA_W-1:0] rsd, rtd;
        logic              rsv, rtv;
    } m_ent_t;

    m_ent_t mq[$];
    int     n_assert = 0;
    int     n_fail   = 0;
    int     exp_sel;
    logic   exp_iv, exp_dr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic m_ent_t wake(input m_ent_t e);
        m_ent_t r = e;
        if (cdb_valid && !r.rsv && cdb_tag == r.rs) begin r.rsd = cdb_data; r.rsv = 1'b1; end
        if (cdb_valid && !r.rtv && cdb_tag == r.rt) begin r.rtd = cdb_data; r.rtv = 1'b1; end
        return r;
    endfunction

    task automatic sample();
        m_ent_t s;
        @(negedge clk);
        exp_sel = -1;
        for (int i = 0; i < mq.size(); i++)
            if (exp_sel < 0 && mq[i].rsv && mq[i].rtv) exp_sel = i;
        exp_iv = (exp_sel >= 0) && !flush;
        exp_dr = !flush && ((mq.size() < DEPTH) || (exp_iv && issue_ack));
        s = '{default: '0};
        if (exp_iv) s = mq[exp_sel];
        chk("issue_valid", issue_valid, exp_iv);
        chk("issue_opcode", issue_opcode, s.op);
        chk("issue_rdtag", issue_rdtag, s.rd);
        chk("issue_rsdata", issue_rsdata, s.rsd);
        chk("issue_rtdata", issue_rtdata, s.rtd);
        chk("count", count, mq.size());
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == DEPTH);
        chk("dispatch_ready", dispatch_ready, exp_dr);
    endtask

    task automatic tick();
        m_ent_t d;
        @(posedge clk);
        if (!reset_n || flush) begin
            mq.delete();
        end else begin
            d = '{op: dispatch_opcode, rd: dispatch_rdtag, rs: dispatch_rstag, rt: dispatch_rttag,
                  rsd: dispatch_rsdata, rtd: dispatch_rtdata, rsv: dispatch_rsvalid, rtv: dispatch_rtvalid};
            for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
            d = wake(d);
            if (exp_iv && issue_ack) mq.delete(exp_sel);
            if (dispatch_en && exp_dr) mq.push_back(d);
        end
        #1;
    endtask

    task automatic idle();
        dispatch_en = 0; dispatch_opcode = '0; dispatch_rdtag = '0; dispatch_rstag = '0;
        dispatch_rttag = '0; dispatch_rsdata = '0; dispatch_rtdata = '0;
        dispatch_rsvalid = 0; dispatch_rtvalid = 0;
        cdb_valid = 0; cdb_tag = '0; cdb_data = '0; flush = 0; issue_ack = 0;
    endtask

    task automatic disp(input logic [OPC_W-1:0] op, input logic [TAG_W-1:0] rd,
                        input logic [TAG_W-1:0] rs, input logic [TAG_W-1:0] rt,
                        input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] rtd,
                        input logic rsv, input logic rtv);
        idle();
        dispatch_en = 1; dispatch_opcode = op; dispatch_rdtag = rd; dispatch_rstag = rs;
        dispatch_rttag = rt; dispatch_rsdata = rsd; dispatch_rtdata = rtd;
        dispatch_rsvalid = rsv; dispatch_rtvalid = rtv;
    endtask

    initial begin
        reset_n = 0;
        idle();
        sample(); tick();
        sample(); tick();
        reset_n = 1;

        // basic dispatch then issue
        disp(6'h05, 6'h01, 6'h02, 6'h03, 32'h11, 32'h22, 1, 1);
        sample(); chk("t1_same_cycle_iv", issue_valid, 0); tick();
        idle(); sample();
        chk("t1_opcode", issue_opcode, 6'h05);
        chk("t1_rsdata", issue_rsdata, 32'h11);
        chk("t1_rtdata", issue_rtdata, 32'h22);
        tick();
        idle(); issue_ack = 1; sample(); tick();
        idle(); sample(); chk("t1_empty", empty, 1); tick();

        // fill with not-ready entries, wake slot 2
        disp(6'h01, 6'h10, 6'h30, 6'h31, 32'h100, 32'h101, 0, 0); sample(); tick();
        disp(6'h01, 6'h11, 6'h32, 6'h33, 32'h110, 32'h111, 0, 0); sample(); tick();
        disp(6'h01, 6'h12, 6'h07, 6'h34, 32'h120, 32'h121, 0, 1); sample(); tick();
        disp(6'h01, 6'h13, 6'h35, 6'h36, 32'h130, 32'h131, 0, 0); sample(); tick();
        idle(); sample();
        chk("t2_full", full, 1);
        chk("t2_dready", dispatch_ready, 0);
        tick();
        idle(); cdb_valid = 1; cdb_tag = 6'h07; cdb_data = 32'hBEEF;
        sample(); chk("t2_no_bypass", issue_valid, 0); tick();
        idle(); issue_ack = 1; sample();
        chk("t2_iv", issue_valid, 1);
        chk("t2_rdtag", issue_rdtag, 6'h12);
        chk("t2_rsdata", issue_rsdata, 32'hBEEF);
        tick();
        idle(); sample(); chk("t2_count", count, 3); tick();

        // full queue: issue and dispatch together
        disp(6'h02, 6'h20, 6'h01, 6'h01, 32'h200, 32'h201, 1, 1); sample(); tick();
        disp(6'h03, 6'h21, 6'h01, 6'h01, 32'h210, 32'h211, 1, 1); issue_ack = 1;
        sample(); chk("t3_dready", dispatch_ready, 1); tick();
        idle(); sample();
        chk("t3_count", count, 4);
        chk("t3_slot3", issue_rdtag, 6'h21);
        tick();
        idle(); issue_ack = 1; sample(); tick();

        // flush with count 3 plus dispatch and CDB
        disp(6'h04, 6'h22, 6'h01, 6'h01, 32'h1, 32'h2, 1, 1);
        flush = 1; cdb_valid = 1; cdb_tag = 6'h30; cdb_data = 32'h5555;
        sample(); chk("t4_flush_iv", issue_valid, 0); tick();
        idle(); sample();
        chk("t4_count", count, 0);
        chk("t4_iv", issue_valid, 0);
        tick();

        // dispatch-port wakeup
        disp(6'h06, 6'h23, 6'h09, 6'h0A, 32'h1234, 32'h77, 0, 1);
        cdb_valid = 1; cdb_tag = 6'h09; cdb_data = 32'hDEAD;
        sample(); tick();
        idle(); sample();
        chk("t5_iv", issue_valid, 1);
        chk("t5_rsdata", issue_rsdata, 32'hDEAD);
        tick();
        idle(); issue_ack = 1; sample(); tick();

        // two ready entries: lower slot first, payload holds without ack
        disp(6'h07, 6'h31, 6'h01, 6'h01, 32'hA1, 32'hB1, 1, 1); sample(); tick();
        disp(6'h08, 6'h32, 6'h01, 6'h01, 32'hA2, 32'hB2, 1, 1); sample(); tick();
        idle(); sample(); chk("t6_first", issue_rdtag, 6'h31); tick();
        idle(); sample();
        chk("t6_hold_rd", issue_rdtag, 6'h31);
        chk("t6_hold_rs", issue_rsdata, 32'hA1);
        tick();
        idle(); issue_ack = 1; sample(); tick();
        idle(); sample(); chk("t6_second", issue_rdtag, 6'h32); tick();
        idle(); issue_ack = 1; sample(); tick();

        // asynchronous reset mid-fill
        disp(6'h09, 6'h40, 6'h01, 6'h01, 32'h1, 32'h1, 1, 1); sample(); tick();
        disp(6'h09, 6'h41, 6'h02, 6'h02, 32'h2, 32'h2, 0, 0); sample(); tick();
        idle();
        #1 reset_n = 0;
        #1;
        chk("t7_async_count", count, 0);
        chk("t7_async_empty", empty, 1);
        chk("t7_async_iv", issue_valid, 0);
        mq.delete();
        #1 reset_n = 1;
        disp(6'h0A, 6'h42, 6'h01, 6'h01, 32'h3, 32'h4, 1, 1);
        sample(); tick();
        idle(); sample();
        chk("t7_first_accept", count, 1);
        tick();
        idle(); issue_ack = 1; sample(); tick();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            dispatch_en      = 1'($urandom_range(0, 1));
            dispatch_opcode  = OPC_W'($urandom);
            dispatch_rdtag   = TAG_W'($urandom);
            dispatch_rstag   = TAG_W'($urandom_range(0, 7));
            dispatch_rttag   = TAG_W'($urandom_range(0, 7));
            dispatch_rsdata  = $urandom;
            dispatch_rtdata  = $urandom;
            dispatch_rsvalid = ($urandom_range(0, 2) == 0);
            dispatch_rtvalid = ($urandom_range(0, 2) == 0);
            cdb_valid        = 1'($urandom_range(0, 1));
            cdb_tag          = TAG_W'($urandom_range(0, 7));
            cdb_data         = $urandom;
            issue_ack        = ($urandom_range(0, 3) != 0);
            flush            = ($urandom_range(0, 40) == 0);
            sample(); tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
